// File: rtl/soc_coulomb_counter_if.sv
// Control, current-sample and SOC/status signals between the SOC integrator
// and its neighbours (current sensor front end, battery model).
interface soc_coulomb_counter_if;
  logic               en_i;
  logic signed [15:0] current_i;
  logic               cur_valid_i;
  logic        [15:0] k_gain_i;
  logic               soc_load_i;
  logic        [15:0] soc_load_val_i;
  logic        [15:0] soc_o;
  logic               bm_en_o;
  logic               soc_valid_o;
  logic               full_o;
  logic               empty_o;
  logic               stale_o;

  modport master (
    output en_i, current_i, cur_valid_i, k_gain_i, soc_load_i, soc_load_val_i,
    input  soc_o, bm_en_o, soc_valid_o, full_o, empty_o, stale_o
  );

  modport slave (
    input  en_i, current_i, cur_valid_i, k_gain_i, soc_load_i, soc_load_val_i,
    output soc_o, bm_en_o, soc_valid_o, full_o, empty_o, stale_o
  );
endinterface

// File: rtl/soc_coulomb_counter.sv
// Coulomb-counting SOC integrator: integrates signed pack current every
// TICK_DIV cycles into a saturating Q1.31 accumulator and strobes the battery model.
module soc_coulomb_counter #(
  parameter int TICK_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  soc_coulomb_counter_if.slave bus
);
  localparam int          TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int          STAGES = 2;
  localparam logic [31:0] ONE    = 32'h8000_0000;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      tick;
  logic               run, step, flush;
  logic [STAGES:0]    vld_pipe;
  logic signed [15:0] cur_q, cur_sel;
  logic               seen, stale_q;
  logic signed [32:0] prod;
  logic signed [31:0] p_q;
  logic signed [33:0] sum;
  logic [31:0]        acc, acc_nxt, sat, load_acc;
  logic               soc_valid_q, full_q, empty_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en_i)  state_nxt = RUN;
      RUN:     if (!bus.en_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run  = (state == RUN) && bus.en_i;
    step = run && (tick == TW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)         tick <= '0;
    else if (!run)      tick <= '0;
    else if (step)      tick <= '0;
    else                tick <= tick + 1'b1;

  // A load or dropping enable kills every in-flight step, including one issued this cycle.
  assign flush   = bus.soc_load_i | ~bus.en_i;
  assign cur_sel = bus.cur_valid_i ? bus.current_i : cur_q;
  assign prod    = cur_sel * $signed({1'b0, bus.k_gain_i});

  // Positive current discharges, so the product is subtracted.
  assign sum = $signed({2'b00, acc}) - $signed({{2{p_q[31]}}, p_q});

  always_comb begin
    if (sum[33])                   sat = '0;
    else if (sum[32:0] > {1'b0, ONE}) sat = ONE;
    else                           sat = sum[31:0];
  end

  assign load_acc = {(bus.soc_load_val_i > 16'h8000) ? 16'h8000 : bus.soc_load_val_i, 16'h0000};

  always_comb begin
    acc_nxt = acc;
    if (bus.soc_load_i)                acc_nxt = load_acc;
    else if (vld_pipe[0] && bus.en_i) acc_nxt = sat;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc         <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      soc_valid_q <= 1'b0;
      vld_pipe    <= '0;
      p_q         <= '0;
    end else begin
      acc         <= acc_nxt;
      full_q      <= (acc_nxt == ONE);
      empty_q     <= (acc_nxt == '0);
      soc_valid_q <= soc_valid_q | bus.soc_load_i;
      vld_pipe    <= flush ? '0 : {vld_pipe[STAGES-1:0], step & soc_valid_q};
      if (step) p_q <= prod[31:0];
    end

  // A sample arriving on the step cycle is consumed by that step and counts as seen.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_q   <= '0;
      seen    <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      if (bus.cur_valid_i) cur_q <= bus.current_i;
      if (step) begin
        stale_q <= ~(seen | bus.cur_valid_i);
        seen    <= 1'b0;
      end else if (bus.cur_valid_i) begin
        seen    <= 1'b1;
      end
    end

  assign bus.soc_o       = acc[31:16];
  assign bus.bm_en_o     = vld_pipe[STAGES];
  assign bus.soc_valid_o = soc_valid_q;
  assign bus.full_o      = full_q;
  assign bus.empty_o     = empty_q;
  assign bus.stale_o     = stale_q;
endmodule

// File: tb/tb_soc_coulomb_counter.sv
// Bench for soc_coulomb_counter: directed test-plan scenarios then random traffic,
// all checked every cycle against an event-scheduled arithmetic model.
module tb_soc_coulomb_counter;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  soc_coulomb_counter_if bus();
  soc_coulomb_counter #(.TICK_DIV(TD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int bm_cnt;

  // model state
  longint m_acc;
  bit     m_run, m_valid, m_full, m_empty, m_stale, m_seen, m_bm;
  int     m_tick, m_cur, pend_p, upd_cnt, str_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_run = 0; m_valid = 0; m_full = 0; m_empty = 1; m_stale = 0;
    m_seen = 0; m_bm = 0; m_tick = 0; m_cur = 0; pend_p = 0; upd_cnt = 0; str_cnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented in that cycle.
  task automatic model_edge();
    bit     ld, en, cv, step, flush;
    int     cur, lv;
    longint s;
    ld    = bus.soc_load_i;
    en    = bus.en_i;
    cv    = bus.cur_valid_i;
    step  = m_run && en && (m_tick == TD - 1);
    cur   = cv ? int'(bus.current_i) : m_cur;
    flush = ld || !en;

    m_bm = (str_cnt == 1) && !flush;
    if (upd_cnt == 1 && !flush) begin
      s = m_acc - longint'(pend_p);
      if (s < 0) s = 0;
      else if (s > 64'h8000_0000) s = 64'h8000_0000;
      m_acc = s;
    end
    if (flush) begin upd_cnt = 0; str_cnt = 0; end
    else begin
      if (upd_cnt > 0) upd_cnt--;
      if (str_cnt > 0) str_cnt--;
    end
    if (ld) begin
      lv = int'(bus.soc_load_val_i);
      if (lv > 32'h8000) lv = 32'h8000;
      m_acc   = longint'(lv) * 65536;
      m_valid = 1;
    end else if (step && m_valid) begin
      pend_p  = cur * int'(bus.k_gain_i);
      upd_cnt = 1;
      str_cnt = 2;
    end
    m_full  = (m_acc == 64'h8000_0000);
    m_empty = (m_acc == 0);

    if (step) begin m_stale = !(m_seen || cv); m_seen = 0; end
    else if (cv) m_seen = 1;
    if (cv) m_cur = int'(bus.current_i);

    if (!(m_run && en) || step) m_tick = 0;
    else m_tick++;
    m_run = en;
  endtask

  task automatic cmp_model();
    logic [31:0] e_soc;
    e_soc = 32'(m_acc >> 16);
    chk("soc",   {16'h0, bus.soc_o}, e_soc);
    chk("bm_en", {31'h0, bus.bm_en_o}, {31'h0, m_bm});
    chk("valid", {31'h0, bus.soc_valid_o}, {31'h0, m_valid});
    chk("full",  {31'h0, bus.full_o}, {31'h0, m_full});
    chk("empty", {31'h0, bus.empty_o}, {31'h0, m_empty});
    chk("stale", {31'h0, bus.stale_o}, {31'h0, m_stale});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_model();
    if (bus.bm_en_o) bm_cnt++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_reset(string pfx);
    chk({pfx, "_soc"},   {16'h0, bus.soc_o}, 32'h0);
    chk({pfx, "_bm"},    {31'h0, bus.bm_en_o}, 32'h0);
    chk({pfx, "_valid"}, {31'h0, bus.soc_valid_o}, 32'h0);
    chk({pfx, "_full"},  {31'h0, bus.full_o}, 32'h0);
    chk({pfx, "_empty"}, {31'h0, bus.empty_o}, 32'h1);
    chk({pfx, "_stale"}, {31'h0, bus.stale_o}, 32'h0);
  endtask

  // One cycle with en_i low carrying an absolute load; restarts step alignment.
  task automatic load_idle(logic [15:0] v, logic [15:0] cur, logic [15:0] k);
    bus.en_i = 1'b0; bus.soc_load_i = 1'b1; bus.soc_load_val_i = v;
    bus.current_i = cur; bus.k_gain_i = k; bus.cur_valid_i = 1'b1;
    cyc();
    bus.soc_load_i = 1'b0; bus.en_i = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en_i = 0; bus.current_i = 0; bus.cur_valid_i = 0; bus.k_gain_i = 0;
    bus.soc_load_i = 0; bus.soc_load_val_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // uninitialised: runs, but no integration and no strobe
    bm_cnt = 0;
    bus.en_i = 1; bus.cur_valid_i = 1; bus.current_i = 16'h0100; bus.k_gain_i = 16'h0100;
    run(20);
    chk("uninit_soc", {16'h0, bus.soc_o}, 32'h0);
    chk("uninit_bm", bm_cnt, 0);

    // nominal discharge: 1 LSB per step
    load_idle(16'h4000, 16'h0100, 16'h0100);
    bm_cnt = 0;
    run(36);
    chk("nom_soc", {16'h0, bus.soc_o}, 32'h3FFC);
    chk("nom_bm", bm_cnt, 4);

    // charge to full
    load_idle(16'h7FFF, 16'hFE00, 16'h0100);
    run(12);
    chk("chg_soc", {16'h0, bus.soc_o}, 32'h8000);
    chk("chg_full", {31'h0, bus.full_o}, 32'h1);
    run(16);
    chk("chg_hold", {16'h0, bus.soc_o}, 32'h8000);

    // drain to empty, then oversized load clamps to 1.0
    load_idle(16'h0001, 16'h0100, 16'h0200);
    run(12);
    chk("drn_soc", {16'h0, bus.soc_o}, 32'h0);
    chk("drn_empty", {31'h0, bus.empty_o}, 32'h1);
    run(8);
    chk("drn_hold", {16'h0, bus.soc_o}, 32'h0);
    bus.soc_load_i = 1; bus.soc_load_val_i = 16'h9000;
    cyc();
    bus.soc_load_i = 0;
    chk("clamp_soc", {16'h0, bus.soc_o}, 32'h8000);
    chk("clamp_full", {31'h0, bus.full_o}, 32'h1);

    // load in the accumulate cycle overrides and suppresses the strobe
    load_idle(16'h4000, 16'h0100, 16'h0100);
    run(9);
    bus.soc_load_i = 1; bus.soc_load_val_i = 16'h2000;
    cyc();
    bus.soc_load_i = 0;
    bm_cnt = 0;
    run(2);
    chk("ldp_soc", {16'h0, bus.soc_o}, 32'h2000);
    chk("ldp_bm", bm_cnt, 0);
    run(8);
    chk("ldp_next", {16'h0, bus.soc_o}, 32'h1FFF);
    chk("ldp_bm2", bm_cnt, 1);

    // stale current: held sample still integrated
    bus.cur_valid_i = 0;
    run(16);
    chk("stale_set", {31'h0, bus.stale_o}, 32'h1);
    chk("stale_soc", {16'h0, bus.soc_o}, 32'h1FFD);
    bus.cur_valid_i = 1;
    run(8);
    chk("stale_clr", {31'h0, bus.stale_o}, 32'h0);
    chk("stale_soc2", {16'h0, bus.soc_o}, 32'h1FFC);

    // enable dropped in the accumulate cycle
    run(5);
    bus.en_i = 0;
    bm_cnt = 0;
    run(4);
    chk("en_soc", {16'h0, bus.soc_o}, 32'h1FFC);
    chk("en_bm", bm_cnt, 0);
    bus.en_i = 1;
    run(9);
    chk("reen_soc", {16'h0, bus.soc_o}, 32'h1FFC);
    run(2);
    chk("reen_soc2", {16'h0, bus.soc_o}, 32'h1FFB);
    chk("reen_bm", bm_cnt, 1);

    // async reset mid-pipeline
    run(6);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.en_i        = ($urandom_range(0, 99) < 95);
      bus.soc_load_i  = ($urandom_range(0, 99) < 2);
      bus.soc_load_val_i = 16'($urandom);
      bus.cur_valid_i = ($urandom_range(0, 3) != 0) && (((i / 40) % 4) != 3);
      if ($urandom_range(0, 7) == 0) bus.current_i = 16'($urandom);
      if ($urandom_range(0, 31) == 0)
        bus.k_gain_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1024));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/soc_coulomb_counter.md
# soc_coulomb_counter

Coulomb-counting state-of-charge integrator that sits directly upstream of the battery model. It integrates signed pack current over a fixed timebase and drives the model's Q1.15 SOC input. It also generates the one-cycle step strobe that advances the model's RC state, timed so the model always sees the updated SOC. The block supports absolute SOC (re)load, saturating arithmetic and stale-current detection.

## Interface
- TICK_DIV, 1000: clock cycles per integration step; must be ≥ 4.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  run enable; low holds SOC and stops stepping.
- current_i  in  16  signed Q8.8 pack current; positive = discharge.
- cur_valid_i  in  1  current_i sample is valid this cycle.
- k_gain_i  in  16  unsigned step gain = dt/(3600·C_Ah)·2^23.
- soc_load_i  in  1  one-cycle request to load an absolute SOC.
- soc_load_val_i  in  16  Q1.15 SOC to load; 1.0 = 0x8000.
- soc_o  out  16  Q1.15 SOC, feeds the battery model SOC input.
- bm_en_o  out  1  one-cycle step strobe to the battery model.
- soc_valid_o  out  1  SOC initialised by at least one load.
- full_o  out  1  SOC saturated at 1.0.
- empty_o  out  1  SOC saturated at 0.
- stale_o  out  1  no valid current sample during the last step period.

## Operation
- State: acc, 32-bit unsigned, Q1.31, 1.0 = 0x8000_0000. soc_o = acc[31:16].
- Sample hold: on cur_valid_i, register current_i into cur_q and set the seen flag.
- FSM:
  - IDLE: entered from reset, or whenever en_i = 0. Tick counter is cleared.
  - IDLE → RUN when en_i = 1.
  - In RUN, the tick counter counts 0..TICK_DIV-1 and wraps. Wrap issues step.
- Step pipeline, active only if soc_valid_o = 1:
  - S1 (cycle after step): P = cur_q × k_gain_i, signed 32-bit, registered.
  - S2: sum = {2'b00, acc} − sign_ext(P), computed in 34-bit signed.
    - sum < 0 → acc = 0.
    - sum > 0x8000_0000 → acc = 0x8000_0000.
    - Otherwise acc = sum[31:0].
    - full_o and empty_o are registered from the new acc.
  - S3: bm_en_o = 1 for exactly one cycle.
- Stale detection: at each step, stale_o = ~seen, then seen is cleared. Integration uses the held cur_q regardless.
- Load:
  - soc_load_i sets acc = {min(soc_load_val_i, 0x8000), 16'h0000}, then soc_valid_o = 1 and full_o/empty_o are updated.
  - Load takes priority over S2 in the same cycle.
  - Load flushes any in-flight step: no acc update and no bm_en_o for it.
  - Load is accepted in IDLE and in RUN.
- en_i falling: the pipeline is flushed and no strobe is issued. acc and all flags are retained.
- Steps with soc_valid_o = 0 advance the counter only: no integration, no strobe. stale_o still updates.
- Simultaneous cur_valid_i and step in one cycle: the new sample is used by S1 and counts as seen for that step.

## Timing
- Reset values: acc = 0, soc_o = 0x0000, bm_en_o = 0, soc_valid_o = 0, full_o = 0, empty_o = 1, stale_o = 0, cur_q = 0, FSM = IDLE.
- First step occurs TICK_DIV cycles after IDLE → RUN. Step period is exactly TICK_DIV cycles.
- soc_o changes at the S2 edge, 2 cycles after step. bm_en_o is high 3 cycles after step, one cycle after soc_o has settled.
- Load reflects on soc_o one cycle after the soc_load_i cycle.
- All outputs are registered. No combinational input-to-output paths.

## Test plan
- Nominal discharge:
  - Stimulus: TICK_DIV = 8, load 0x4000, current_i = 0x0100 valid, k_gain_i = 0x0100, 4 steps.
  - Required: soc_o decrements 1 LSB per step to 0x3FFC. bm_en_o pulses every 8 cycles, 3 cycles after each wrap.
- Charge to full:
  - Stimulus: load 0x7FFF, current_i = 0xFE00 (−2 A), k_gain_i = 0x0100.
  - Required: after one step soc_o = 0x8000 and full_o = 1. Further steps hold 0x8000.
- Drain to empty:
  - Stimulus: load 0x0001, current_i = 0x0100, k_gain_i = 0x0200.
  - Required: after one step soc_o = 0x0000, empty_o = 1, no wrap-around. Load 0x9000 then gives soc_o = 0x8000.
- Load during pipeline:
  - Stimulus: assert soc_load_i = 0x2000 in the S2 cycle.
  - Required: soc_o = 0x2000, no bm_en_o for that step, next step integrates normally.
- Uninitialised / stale:
  - Stimulus: run with no load.
  - Required: soc_o = 0 and no bm_en_o.
  - Stimulus: after load, drop cur_valid_i for a full step period.
  - Required: stale_o = 1 and the held current is still integrated. The next valid sample clears stale_o at the following step.
- Reset and enable mid-operation:
  - Stimulus: deassert rst_n in S1.
  - Required: all outputs return to their reset values immediately.
  - Stimulus: en_i low in S1.
  - Required: no strobe, SOC retained, counter restarts on re-enable.
